// File: rtl/mips32_pkg.sv
// Definitions shared across the mips32 core: instruction and memory widths
// and the state encoding of the host-side program loader.
package mips32_pkg;

    localparam int INSTR_W     = 32;
    localparam int IMEM_ADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        DONE
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted stream bytes MSB-first into 32-bit instruction words and
// flags the byte that completes each word.
module word_assembler
    import mips32_pkg::*;
(
    input  logic               clk_x,
    input  logic               rst_n_x,
    input  logic               i_clear,
    input  logic               i_accept,
    input  logic [7:0]         i_byte,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_word_done
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    always_ff @(posedge clk_x or negedge rst_n_x) begin
        if (!rst_n_x) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_cnt   <= '0;
        end else if (i_accept) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
        end
    end

    // The completing byte is merged combinationally so the word is ready in its accept cycle.
    assign o_word      = {r_shift, i_byte};
    assign o_word_done = i_accept && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Host-side program loader: parses a counted big-endian byte stream, writes the
// words into instruction memory and holds the core until the load completes.
module imem_loader
    import mips32_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int DATA_W    = INSTR_W,
    parameter int LOAD_BASE = 0
) (
    input  logic              clk_x,
    input  logic              rst_n_x,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err_ovf,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] WL_MAX = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t      r_state;
    loader_state_t      w_state_next;
    logic [15:0]        r_n;
    logic [15:0]        r_idx;
    logic               w_accept;
    logic               w_session_start;
    logic               w_word_done;
    logic               w_last_word;
    logic               w_in_range;
    logic               w_write;
    logic [31:0]        w_addr_full;
    logic [INSTR_W-1:0] w_word;

    assign w_accept        = in_valid && in_ready;
    assign w_session_start = (r_state == IDLE) && start;
    // Full-width address so words past the top of memory are detected, never wrapped.
    assign w_addr_full     = 32'(LOAD_BASE) + {16'd0, r_idx};
    assign w_in_range      = w_addr_full <= 32'((2 ** ADDR_W) - 1);
    assign w_last_word     = (r_idx == r_n - 16'd1);
    assign w_write         = w_word_done && w_in_range;

    word_assembler u_word_assembler (
        .clk_x       (clk_x),
        .rst_n_x     (rst_n_x),
        .i_clear     (w_session_start),
        .i_accept    (w_accept && (r_state == DATA)),
        .i_byte      (in_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clk_x or negedge rst_n_x) begin
        if (!rst_n_x) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = HDR_HI;
            HDR_HI:  if (w_accept) w_state_next = HDR_LO;
            HDR_LO:  if (w_accept) w_state_next = ({r_n[15:8], in_data} == 16'd0) ? DONE : DATA;
            DATA:    if (w_word_done && w_last_word) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_x or negedge rst_n_x) begin
        if (!rst_n_x) begin
            in_ready     <= 1'b0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            cpu_run      <= 1'b0;
            busy         <= 1'b0;
            err_ovf      <= 1'b0;
            words_loaded <= '0;
            r_n          <= '0;
            r_idx        <= '0;
        end else begin
            in_ready <= (w_state_next == HDR_HI) || (w_state_next == HDR_LO) ||
                        (w_state_next == DATA);
            im_we    <= w_write;
            if (w_write) begin
                im_addr  <= w_addr_full[ADDR_W-1:0];
                im_wdata <= w_word;
            end
            if (w_session_start) begin
                cpu_run      <= 1'b0;
                busy         <= 1'b1;
                err_ovf      <= 1'b0;
                words_loaded <= '0;
                r_idx        <= '0;
            end
            if (r_state == DONE) begin
                busy    <= 1'b0;
                cpu_run <= 1'b1;
            end
            if (w_accept && (r_state == HDR_HI)) r_n[15:8] <= in_data;
            if (w_accept && (r_state == HDR_LO)) r_n[7:0]  <= in_data;
            if (w_word_done) begin
                r_idx <= r_idx + 16'd1;
                if (!w_in_range) err_ovf <= 1'b1;
            end
            if (w_write && (words_loaded != WL_MAX)) words_loaded <= words_loaded + 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: two instances (base 0 and base 1022)
// receive the same streams and are compared against a word-list reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready_a, im_we_a, cpu_run_a, busy_a, err_ovf_a;
    logic [9:0]  im_addr_a;
    logic [31:0] im_wdata_a;
    logic [10:0] words_loaded_a;
    logic        in_ready_b, im_we_b, cpu_run_b, busy_b, err_ovf_b;
    logic [9:0]  im_addr_b;
    logic [31:0] im_wdata_b;
    logic [10:0] words_loaded_b;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [41:0] wq_a[$];
    logic [41:0] wq_b[$];
    logic [31:0] prog[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(10), .DATA_W(32), .LOAD_BASE(0)) dut_a (
        .clk_x(clk), .rst_n_x(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .im_we(im_we_a), .im_addr(im_addr_a), .im_wdata(im_wdata_a),
        .cpu_run(cpu_run_a), .busy(busy_a), .err_ovf(err_ovf_a), .words_loaded(words_loaded_a)
    );

    imem_loader #(.ADDR_W(10), .DATA_W(32), .LOAD_BASE(1022)) dut_b (
        .clk_x(clk), .rst_n_x(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .im_we(im_we_b), .im_addr(im_addr_b), .im_wdata(im_wdata_b),
        .cpu_run(cpu_run_b), .busy(busy_b), .err_ovf(err_ovf_b), .words_loaded(words_loaded_b)
    );

    // Every write strobe is logged once; im_we lasts a whole cycle so one negedge sees it.
    always @(negedge clk) begin
        if (im_we_a) wq_a.push_back({im_addr_a, im_wdata_a});
        if (im_we_b) wq_b.push_back({im_addr_b, im_wdata_b});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int t = 0;
        in_data = 8'($urandom);
        if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready_a && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ready_timeout", in_ready_a, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_set"}, busy_a, 1);
        chk({tag, "_run_drop"}, cpu_run_a, 0);
        chk({tag, "_err_clr"}, err_ovf_b, 0);
        chk({tag, "_wl_clr"}, words_loaded_b, 0);
    endtask

    // Reference model: word i goes to base+i if it fits, otherwise it is dropped and flags overflow.
    task automatic check_session(input string tag, input bit sel);
        int          base;
        int          exp_n;
        bit          exp_err;
        logic [31:0] last_w;
        logic [41:0] got[$];
        base    = sel ? 1022 : 0;
        exp_n   = 0;
        exp_err = 1'b0;
        last_w  = '0;
        got     = sel ? wq_b : wq_a;
        for (int i = 0; i < prog.size(); i++) begin
            if (base + i <= 1023) begin
                if (exp_n < got.size())
                    chk($sformatf("%s_wr%0d", tag, exp_n), got[exp_n], {10'(base + i), prog[i]});
                exp_n++;
                last_w = prog[i];
            end else begin
                exp_err = 1'b1;
            end
        end
        chk({tag, "_nwr"}, got.size(), exp_n);
        chk({tag, "_err"}, sel ? err_ovf_b : err_ovf_a, exp_err);
        chk({tag, "_wl"}, sel ? words_loaded_b : words_loaded_a, exp_n);
        if (exp_n > 0) chk({tag, "_wdata_hold"}, sel ? im_wdata_b : im_wdata_a, last_w);
    endtask

    task automatic run_load(input string tag, input int gap_max, input int inj_start);
        logic [15:0] nn;
        logic [31:0] w;
        nn = 16'(prog.size());
        wq_a.delete();
        wq_b.delete();
        pulse_start(tag);
        send_byte(nn[15:8], gap_max);
        send_byte(nn[7:0], gap_max);
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            for (int j = 3; j >= 0; j--) begin
                if (inj_start == i * 4 + (3 - j)) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                send_byte(w[j*8 +: 8], gap_max);
            end
        end
        chk({tag, "_run_still_lo"}, cpu_run_a, 0);
        chk({tag, "_busy_still"}, busy_a, 1);
        @(negedge clk);
        chk({tag, "_run_hi"}, cpu_run_a, 1);
        chk({tag, "_run_hi_b"}, cpu_run_b, 1);
        chk({tag, "_busy_clr"}, busy_a, 0);
        chk({tag, "_rdy_lo"}, in_ready_a, 0);
        check_session({tag, "_a"}, 1'b0);
        check_session({tag, "_b"}, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] nn;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready_a, 0);
        chk("rst_we", im_we_a, 0);
        chk("rst_run", cpu_run_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_err", err_ovf_a, 0);
        chk("rst_wl", words_loaded_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        prog = '{32'hC020_0001, 32'hC040_0002};
        run_load("t1", 0, -1);

        // Byte offered in IDLE must not be taken.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_rdy", in_ready_a, 0);
        chk("idle_run_kept", cpu_run_a, 1);
        in_valid = 1'b0;
        prog.delete();
        run_load("t2", 2, -1);

        prog.delete();
        prog.push_back(32'h0000_0000);
        for (int i = 0; i < 16; i++) prog.push_back($urandom);
        prog.push_back(32'hC480_0003);
        run_load("t3", 3, -1);

        prog.delete();
        for (int i = 0; i < 4; i++) prog.push_back($urandom);
        run_load("t4", 1, -1);

        prog = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        wq_a.delete();
        wq_b.delete();
        pulse_start("t5");
        nn = 16'd3;
        send_byte(nn[15:8], 0);
        send_byte(nn[7:0], 0);
        send_byte(8'h11, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", in_ready_a, 0);
        chk("t5_rst_busy", busy_a, 0);
        chk("t5_rst_addr", im_addr_a, 0);
        chk("t5_rst_wdata", im_wdata_a, 0);
        chk("t5_rst_wl", words_loaded_b, 0);
        chk("t5_rst_addr_b", im_addr_b, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_we", wq_a.size(), 0);
        chk("t5_held", cpu_run_a, 0);
        prog.delete();
        for (int i = 0; i < 3; i++) prog.push_back($urandom);
        run_load("t5b", 1, -1);

        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back($urandom);
        run_load("t6a", 1, 9);
        chk("t6_run_before_reload", cpu_run_a, 1);
        prog.delete();
        for (int i = 0; i < 3; i++) prog.push_back($urandom);
        run_load("t6b", 0, -1);

        for (int k = 0; k < 4; k++) begin
            prog.delete();
            repeat ($urandom_range(6, 1)) prog.push_back($urandom);
            run_load($sformatf("rnd%0d", k), 2, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
